// File: rtl/mem_copy_engine_if.sv
// Control and data-memory bus bundle for mem_copy_engine.
// The master side is the engine; the slave side is the host plus data memory.
interface mem_copy_engine_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 9
);
   logic              start;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [LEN_W-1:0]  length;
   logic              busy;
   logic              done;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  start, src_addr, dst_addr, length, mem_rdata,
      output busy, done, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output start, src_addr, dst_addr, length, mem_rdata,
      input  busy, done, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy initiator for the single-port data memory: one read then one write per word,
// ascending order, two cycles per word.
module mem_copy_engine #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   mem_copy_engine_if.master bus
);

   localparam int unsigned MAX_LEN = 2 ** (LEN_W - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx;
   logic [DATA_W-1:0] buffer;

   logic [LEN_W-1:0]  len_clamped_c;
   logic [LEN_W-1:0]  idx_inc_c;

   // Lengths above the memory size collapse to a full-memory copy
   assign len_clamped_c = (bus.length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.length;
   assign idx_inc_c     = idx + LEN_W'(1);
   assign bus.mem_wdata = buffer;

   // Outputs are computed one edge ahead so they are registered and valid for the whole state
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         idx          <= '0;
         buffer       <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.done   <= 1'b0;
               bus.mem_we <= 1'b0;
               if (bus.start) begin
                  src_q <= bus.src_addr;
                  dst_q <= bus.dst_addr;
                  len_q <= len_clamped_c;
                  idx   <= '0;
                  if (len_clamped_c != '0) begin
                     state        <= READ;
                     bus.busy     <= 1'b1;
                     bus.mem_addr <= bus.src_addr;
                  end else begin
                     state        <= DONE;
                     bus.busy     <= 1'b0;
                     bus.done     <= 1'b1;
                     bus.mem_addr <= '0;
                  end
               end
            end
            READ: begin
               buffer       <= bus.mem_rdata;
               state        <= WRITE;
               bus.mem_we   <= 1'b1;
               bus.mem_addr <= dst_q + ADDR_W'(idx);
            end
            WRITE: begin
               idx <= idx_inc_c;
               if (idx_inc_c == len_q) begin
                  state        <= DONE;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= '0;
               end else begin
                  state        <= READ;
                  bus.mem_we   <= 1'b0;
                  bus.mem_addr <= src_q + ADDR_W'(idx_inc_c);
               end
            end
            DONE: begin
               state        <= IDLE;
               bus.busy     <= 1'b0;
               bus.done     <= 1'b0;
               bus.mem_we   <= 1'b0;
               bus.mem_addr <= '0;
            end
            default: begin
               state        <= IDLE;
               bus.busy     <= 1'b0;
               bus.done     <= 1'b0;
               bus.mem_we   <= 1'b0;
               bus.mem_addr <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256x16 behavioural data memory.
module tb_mem_copy_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_copy_engine_if bus ();

   mem_copy_engine dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem [256];
   logic        ld_we;
   logic [7:0]  ld_addr;
   logic [15:0] ld_data;

   // Engine writes take the port; the bench loader only uses it while the engine is idle
   always @(posedge clk) begin
      if (bus.mem_we)
         mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else if (ld_we)
         mem[ld_addr] <= ld_data;
   end
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] rd_addrs [$];

   always @(negedge clk) begin
      if (bus.busy && !bus.mem_we)
         rd_addrs.push_back(bus.mem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // k counts cycles after the start edge E0; done_at is the k where done was seen
   task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [8:0] n,
                          input int poke_k, output int done_at, output int busy_cyc,
                          output int we_cyc, output int done_cnt);
      done_at = -1; busy_cyc = 0; we_cyc = 0; done_cnt = 0;
      @(negedge clk);
      bus.src_addr = s; bus.dst_addr = d; bus.length = n; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 1100; k++) begin
         if (k == poke_k) begin
            bus.start    = 1'b1;
            bus.src_addr = 16'h0070;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.busy)   busy_cyc++;
         if (bus.mem_we) we_cyc++;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (done_at >= 0 && k >= done_at + 2) break;
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   int done_at, busy_cyc, we_cyc, done_cnt;
   int late_done;

   initial begin
      rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy",  32'(bus.busy),      32'h0);
      chk("rst_done",  32'(bus.done),      32'h0);
      chk("rst_we",    32'(bus.mem_we),    32'h0);
      chk("rst_addr",  32'(bus.mem_addr),  32'h0);
      chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
      rst = 1'b0;

      // Basic 4-word copy
      poke(8'h10, 16'h00A1); poke(8'h11, 16'h00B2); poke(8'h12, 16'h00C3); poke(8'h13, 16'h00D4);
      do_copy(16'h0010, 16'h0040, 9'd4, -1, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t1_done_at", 32'(done_at),  32'd8);
      chk("t1_done_n",  32'(done_cnt), 32'd1);
      chk("t1_busy",    32'(busy_cyc), 32'd8);
      chk("t1_we",      32'(we_cyc),   32'd4);
      chk("t1_m40", 32'(mem[8'h40]), 32'h00A1);
      chk("t1_m41", 32'(mem[8'h41]), 32'h00B2);
      chk("t1_m42", 32'(mem[8'h42]), 32'h00C3);
      chk("t1_m43", 32'(mem[8'h43]), 32'h00D4);

      // Zero length
      do_copy(16'h0010, 16'h0050, 9'd0, -1, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t2_done_at", 32'(done_at),  32'd0);
      chk("t2_done_n",  32'(done_cnt), 32'd1);
      chk("t2_busy",    32'(busy_cyc), 32'd0);
      chk("t2_we",      32'(we_cyc),   32'd0);

      // Source crossing the 256-word boundary
      poke(8'hFE, 16'h1111); poke(8'hFF, 16'h2222); poke(8'h00, 16'h3333); poke(8'h01, 16'h4444);
      rd_addrs.delete();
      do_copy(16'h00FE, 16'h0080, 9'd4, -1, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t3_nrd", 32'(rd_addrs.size()), 32'd4);
      chk("t3_rd0", 32'(rd_addrs[0]), 32'h00FE);
      chk("t3_rd1", 32'(rd_addrs[1]), 32'h00FF);
      chk("t3_rd2", 32'(rd_addrs[2]), 32'h0100);
      chk("t3_rd3", 32'(rd_addrs[3]), 32'h0101);
      chk("t3_m80", 32'(mem[8'h80]), 32'h1111);
      chk("t3_m81", 32'(mem[8'h81]), 32'h2222);
      chk("t3_m82", 32'(mem[8'h82]), 32'h3333);
      chk("t3_m83", 32'(mem[8'h83]), 32'h4444);

      // Start re-pulsed mid-copy with a different source is ignored
      poke(8'h40, 16'h0); poke(8'h41, 16'h0); poke(8'h42, 16'h0); poke(8'h43, 16'h0);
      poke(8'h70, 16'hDEAD);
      do_copy(16'h0010, 16'h0040, 9'd4, 3, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t4_done_at", 32'(done_at),  32'd8);
      chk("t4_done_n",  32'(done_cnt), 32'd1);
      chk("t4_we",      32'(we_cyc),   32'd4);
      chk("t4_m40", 32'(mem[8'h40]), 32'h00A1);
      chk("t4_m43", 32'(mem[8'h43]), 32'h00D4);

      // Reset during the second write
      poke(8'h40, 16'h0); poke(8'h41, 16'h0); poke(8'h42, 16'h0); poke(8'h43, 16'h0);
      @(negedge clk);
      bus.src_addr = 16'h0010; bus.dst_addr = 16'h0040; bus.length = 9'd4; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_we_w1", 32'(bus.mem_we), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_busy", 32'(bus.busy),     32'h0);
      chk("t5_done", 32'(bus.done),     32'h0);
      chk("t5_we",   32'(bus.mem_we),   32'h0);
      chk("t5_addr", 32'(bus.mem_addr), 32'h0);
      rst = 1'b0;
      late_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.busy) late_done++;
      end
      chk("t5_quiet", 32'(late_done), 32'd0);
      chk("t5_m40", 32'(mem[8'h40]), 32'h00A1);
      chk("t5_m41", 32'(mem[8'h41]), 32'h00B2);
      chk("t5_m42", 32'(mem[8'h42]), 32'h0000);
      chk("t5_m43", 32'(mem[8'h43]), 32'h0000);
      do_copy(16'h0010, 16'h0040, 9'd4, -1, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t5_re_done_at", 32'(done_at), 32'd8);
      chk("t5_re_m42", 32'(mem[8'h42]), 32'h00C3);
      chk("t5_re_m43", 32'(mem[8'h43]), 32'h00D4);

      // Overlapping forward copy propagates the first word
      poke(8'h20, 16'h0001); poke(8'h21, 16'h0002); poke(8'h22, 16'h0003);
      do_copy(16'h0020, 16'h0021, 9'd2, -1, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t6_m20", 32'(mem[8'h20]), 32'h0001);
      chk("t6_m21", 32'(mem[8'h21]), 32'h0001);
      chk("t6_m22", 32'(mem[8'h22]), 32'h0001);

      // Over-long length clamps to 256 words
      do_copy(16'h0000, 16'h0000, 9'd300, -1, done_at, busy_cyc, we_cyc, done_cnt);
      chk("t7_done_at", 32'(done_at),  32'd512);
      chk("t7_busy",    32'(busy_cyc), 32'd512);
      chk("t7_we",      32'(we_cyc),   32'd256);
      chk("t7_m40",     32'(mem[8'h40]), 32'h00A1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
